fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO, in the write clock domain. It shares the FIFO's single write port (wr_en, data_in) among NUM_REQ producers, each using a valid/ready handshake. A grant is held for a burst of up to BURST_LEN words, and the burst is shortened while the FIFO reports half. It never writes while full is asserted.

## Interface
Parameters:
- DATA_WIDTH, 8: word width; matches the FIFO data_in.
- NUM_REQ, 4: number of requesters, 2..8.
- BURST_LEN, 4: maximum words per grant, 1..16.

Ports:
- clk_wr  in  1: write-domain clock, the only clock.
- rst  in  1: asynchronous, active-high reset.
- req_valid  in  NUM_REQ: requester i has a word on req_data[i].
- req_data  in  NUM_REQ*DATA_WIDTH: packed; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ: word of requester i accepted this cycle.
- full  in  1: FIFO full flag, write domain.
- half  in  1: FIFO half flag, write domain.
- wr_en  out  1: FIFO write enable.
- data_in  out  DATA_WIDTH: FIFO write data.
- grant  out  NUM_REQ: registered one-hot current owner; all zeros when idle.
- busy  out  1: state is not IDLE.
- wr_count  out  16: total words written; wraps modulo 2^16.

## Operation
- State machine states: IDLE, BURST, STALL. Registers: state, grant, gidx (owner index), last (index of the last owner), burst_cnt (5 bits), wr_count.
- Write rule, combinational: wr_en = (state==BURST) & req_valid[gidx] & ~full.
  - req_ready = grant & {NUM_REQ{wr_en}}.
  - data_in = req_data[gidx] when state==BURST, otherwise 0.
- Effective limit: lim = half ? max(BURST_LEN>>1, 1) : BURST_LEN. lim is sampled every cycle, so a change on half takes effect immediately.
- Round-robin pick: the first i with req_valid[i] set, searching from (last+1) mod NUM_REQ upward with wrap. This choice sets grant, gidx and last, and clears burst_cnt.
- IDLE:
  - If any req_valid is set: pick, then go to BURST.
  - Otherwise stay in IDLE.
- BURST, release conditions:
  - A write occurs and burst_cnt+1 >= lim.
  - Or req_valid[gidx] is 0 (the owner dropped valid, no write occurs).
- BURST, on release:
  - If any other requester has valid set (the current owner excluded, since last=gidx), pick it, stay in BURST, with a new grant next cycle.
  - Else if the current owner is still valid, regrant it with burst_cnt cleared.
  - Else go to IDLE with grant=0.
- BURST, no release:
  - If a write occurs: burst_cnt increments.
  - If full=1 and req_valid[gidx]=1: go to STALL, holding grant and burst_cnt.
- STALL:
  - wr_en=0.
  - When full=0, return to BURST; the write happens in the BURST cycle, not in STALL.
  - If req_valid[gidx] drops during STALL, return to BURST, which then releases.
- wr_count increments on every wr_en cycle.
- Reset values: state=IDLE, grant=0, gidx=0, last=NUM_REQ-1 (so requester 0 wins first), burst_cnt=0, wr_count=0, busy=0, wr_en=0, req_ready=0, data_in=0.

## Timing
- Arbitration latency: from IDLE, the earliest write is 1 cycle after req_valid rises.
- Back-to-back owner handoff has one dead cycle on the release cycle's successor only if the new owner's valid is low. Otherwise the write in the first new-grant cycle is allowed, giving full throughput across owners.
- full is respected in the same cycle (combinational gating); no write is ever issued with full=1.
- Reset mid-burst: all outputs clear asynchronously. In-flight handshakes are dropped, and requesters must retain their data because ready was never asserted.
- Requesters must hold req_data stable while req_valid=1 and req_ready=0.

## Test plan
- Single requester: reset, then req_valid=4'b0001 with data 0x10..0x15 presented as each prior word is accepted.
  - Expect grant 0001 from cycle 1.
  - Words 0x10–0x13 are written, a regrant follows (no other requester), and 0x14–0x15 are written.
  - wr_count=6.
- Fairness: all four requesters valid continuously, BURST_LEN=4, half=0.
  - Grant sequence 0001, 0010, 0100, 1000, 0001, with 4 writes each and no idle cycles.
  - wr_count=20 after 20 write cycles.
- Half throttle: half=1, two requesters valid.
  - Bursts of 2 words alternating between owners.
  - half deasserting mid-burst allows the current burst to reach 4 words.
- Full stall: full asserted after the 2nd word of a burst for 5 cycles.
  - wr_en=0 and the state is STALL for 5 cycles.
  - The burst resumes and completes with words 3–4; no write occurs with full=1.
- Valid drop: owner 1 drops valid after 1 word while requester 3 is valid. Expect a handoff to grant 1000 next cycle.
- Reset mid-burst: assert rst during the 3rd word. Expect grant=0, wr_en=0 and wr_count=0 immediately; requester 0 wins first after release.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready producers.
// Grants last up to BURST_LEN words (halved while half=1); writes are gated by full.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                            clk_wr,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            full,
   input  logic                            half,
   output logic                            wr_en,
   output logic [DATA_WIDTH-1:0]           data_in,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            busy,
   output logic [15:0]                     wr_count,
   output logic [1:0]                      dbg_state
);

   localparam int IDX_W    = $clog2(NUM_REQ);
   localparam int HALF_LEN = ((BURST_LEN >> 1) > 0) ? (BURST_LEN >> 1) : 1;

   // Handshake: a word moves from requester i when req_valid[i] and req_ready[i]
   // are both high on a rising clk_wr; req_ready is only ever high for the owner.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
   logic [IDX_W-1:0]     r_gidx, w_gidx_nxt;
   logic [IDX_W-1:0]     r_last, w_last_nxt;
   logic [4:0]           r_burst_cnt, w_burst_cnt_nxt;
   logic [15:0]          r_wr_count;
   logic [4:0]           w_lim;
   logic                 w_owner_valid;
   logic                 w_wr;
   logic                 w_pick_found;
   logic [IDX_W-1:0]     w_pick_idx;
   logic [IDX_W-1:0]     w_cand;
   logic                 w_take_pick;

   assign w_lim         = half ? 5'(HALF_LEN) : 5'(BURST_LEN);
   assign w_owner_valid = req_valid[r_gidx];
   assign w_wr          = (r_state == S_BURST) & w_owner_valid & ~full;

   assign wr_en     = w_wr;
   assign req_ready = r_grant & {NUM_REQ{w_wr}};
   assign data_in   = (r_state == S_BURST) ? req_data[r_gidx*DATA_WIDTH +: DATA_WIDTH]
                                           : '0;
   assign grant     = r_grant;
   assign busy      = (r_state != S_IDLE);
   assign wr_count  = r_wr_count;
   assign dbg_state = r_state;

   // Search from last+1 with wrap; the owner itself is the final candidate,
   // so a release with no other requester naturally regrants the owner.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
         if (req_valid[w_cand]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_gidx_nxt      = r_gidx;
      w_last_nxt      = r_last;
      w_burst_cnt_nxt = r_burst_cnt;
      w_take_pick     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pick_found) w_take_pick = 1'b1;
         end
         S_BURST: begin
            if ((w_wr && ((r_burst_cnt + 5'd1) >= w_lim)) || !w_owner_valid) begin
               if (w_pick_found) begin
                  w_take_pick = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_grant_nxt = '0;
               end
            end else if (w_wr) begin
               w_burst_cnt_nxt = r_burst_cnt + 5'd1;
            end else if (full) begin
               w_state_nxt = S_STALL;
            end
         end
         S_STALL: begin
            if (!full || !w_owner_valid) w_state_nxt = S_BURST;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
      endcase
      if (w_take_pick) begin
         w_state_nxt             = S_BURST;
         w_grant_nxt             = '0;
         w_grant_nxt[w_pick_idx] = 1'b1;
         w_gidx_nxt              = w_pick_idx;
         w_last_nxt              = w_pick_idx;
         w_burst_cnt_nxt         = '0;
      end
   end

   always_ff @(posedge clk_wr or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_gidx      <= '0;
         r_last      <= IDX_W'(NUM_REQ - 1);
         r_burst_cnt <= '0;
         r_wr_count  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_gidx      <= w_gidx_nxt;
         r_last      <= w_last_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         if (w_wr) r_wr_count <= r_wr_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural round-robin model.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int BL = 4;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   logic              clk_wr = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              full;
   logic              half;
   logic              wr_en;
   logic [DW-1:0]     data_in;
   logic [NR-1:0]     grant;
   logic              busy;
   logic [15:0]       wr_count;
   logic [1:0]        dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: who owns the port, how many words it has moved, whether parked on full.
   bit            m_active;
   bit            m_stalled;
   int            m_owner;
   int            m_last;
   int            m_words;
   int            m_count;
   logic [DW-1:0] word_ctr [NR];
   int            wr_owner_q[$];
   logic [DW-1:0] exp_q[$];

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
      .clk_wr    (clk_wr),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .full      (full),
      .half      (half),
      .wr_en     (wr_en),
      .data_in   (data_in),
      .grant     (grant),
      .busy      (busy),
      .wr_count  (wr_count),
      .dbg_state (dbg_state)
   );

   always #5 clk_wr = ~clk_wr;

   always_comb begin
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_ctr[i];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_active  = 1'b0;
      m_stalled = 1'b0;
      m_owner   = 0;
      m_last    = NR - 1;
      m_words   = 0;
      m_count   = 0;
      wr_owner_q.delete();
      exp_q.delete();
   endtask

   // One clock: drive inputs, compare every output with the model, advance the model.
   task automatic cycle(input logic [NR-1:0] v, input logic f, input logic h);
      logic [NR-1:0] e_grant;
      logic [NR-1:0] e_ready;
      logic [DW-1:0] e_data;
      logic [1:0]    e_state;
      logic          e_wr;
      bit            ov;
      int            lim;
      int            p;
      int            prev_owner;
      req_valid = v;
      full      = f;
      half      = h;
      #2;
      ov      = v[m_owner];
      e_wr    = m_active && !m_stalled && ov && !f;
      e_grant = m_active ? NR'(1 << m_owner) : '0;
      e_ready = e_wr ? e_grant : '0;
      e_data  = (m_active && !m_stalled) ? word_ctr[m_owner] : '0;
      e_state = !m_active ? ST_IDLE : (m_stalled ? ST_STALL : ST_BURST);
      chk("wr_en", wr_en, e_wr);
      chk("grant", grant, e_grant);
      chk("req_ready", req_ready, e_ready);
      chk("data_in", data_in, e_data);
      chk("busy", busy, m_active);
      chk("state", dbg_state, e_state);
      chk("wr_count", wr_count, m_count);
      if (e_wr) begin
         wr_owner_q.push_back(m_owner);
         exp_q.push_back(word_ctr[m_owner]);
         m_count = (m_count + 1) % 65536;
      end
      if (wr_en === 1'b1) begin
         if (exp_q.size() > 0) chk("sb_data", data_in, exp_q.pop_front());
         else chk("sb_unexpected_write", wr_en, 1'b0);
      end
      lim        = h ? ((BL / 2 > 0) ? BL / 2 : 1) : BL;
      prev_owner = m_owner;
      if (!m_active) begin
         p = rr_pick(v, m_last);
         if (p >= 0) begin
            m_active = 1'b1; m_owner = p; m_last = p; m_words = 0;
         end
      end else if (m_stalled) begin
         if (!f || !ov) m_stalled = 1'b0;
      end else if ((e_wr && (m_words + 1 >= lim)) || !ov) begin
         p = rr_pick(v, m_last);
         if (p >= 0) begin
            m_owner = p; m_last = p; m_words = 0;
         end else begin
            m_active = 1'b0;
         end
      end else if (e_wr) begin
         m_words++;
      end else if (f) begin
         m_stalled = 1'b1;
      end
      @(posedge clk_wr);
      #1;
      if (e_wr) word_ctr[prev_owner] = word_ctr[prev_owner] + 8'd1;
   endtask

   task automatic run_writes(input logic [NR-1:0] v, input logic f, input logic h,
                             input int target, input int budget, output int ncyc);
      ncyc = 0;
      while (wr_owner_q.size() < target && ncyc < budget) begin
         cycle(v, f, h);
         ncyc++;
      end
      chk("write_budget", wr_owner_q.size(), target);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      full      = 1'b0;
      half      = 1'b0;
      model_reset();
      @(posedge clk_wr);
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_data_in", data_in, 0);
      chk("rst_ready", req_ready, 0);
      rst = 1'b0;
   endtask

   initial begin
      int ncyc;
      int stalls;
      int exp3 [11];
      logic [NR-1:0] rv;
      exp3 = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < NR; i++) word_ctr[i] = 8'(i * 8'h40);
      rst = 1'b1;

      // single requester: 4-word burst, regrant, 2 more words
      do_reset();
      word_ctr[0] = 8'h10;
      cycle(4'b0001, 1'b0, 1'b0);
      chk("t1_first_grant", grant, 4'b0001);
      run_writes(4'b0001, 1'b0, 1'b0, 6, 40, ncyc);
      chk("t1_wr_count", wr_count, 6);
      chk("t1_next_word", word_ctr[0], 8'h16);

      // fairness: all valid, 4 words per owner, no idle cycle
      do_reset();
      run_writes(4'b1111, 1'b0, 1'b0, 20, 60, ncyc);
      chk("t2_cycles", ncyc, 21);
      chk("t2_wr_count", wr_count, 20);
      for (int k = 0; k < 20 && k < wr_owner_q.size(); k++)
         chk("t2_owner", wr_owner_q[k], (k / 4) % 4);

      // half throttle, then half drops mid-burst
      do_reset();
      run_writes(4'b0011, 1'b0, 1'b1, 7, 40, ncyc);
      run_writes(4'b0011, 1'b0, 1'b0, 11, 40, ncyc);
      for (int k = 0; k < 11 && k < wr_owner_q.size(); k++)
         chk("t3_owner", wr_owner_q[k], exp3[k]);

      // full for 5 cycles after the 2nd word of a burst
      do_reset();
      run_writes(4'b0001, 1'b0, 1'b0, 2, 20, ncyc);
      stalls = 0;
      for (int k = 0; k < 5; k++) begin
         cycle(4'b0001, 1'b1, 1'b0);
         if (dbg_state == ST_STALL) stalls++;
      end
      cycle(4'b0001, 1'b0, 1'b0);
      chk("t4_stall_cycles", stalls, 5);
      chk("t4_no_write_in_full", wr_owner_q.size(), 2);
      run_writes(4'b0001, 1'b0, 1'b0, 4, 20, ncyc);
      chk("t4_wr_count", wr_count, 4);

      // owner 1 drops valid after one word, requester 3 takes over
      do_reset();
      cycle(4'b1010, 1'b0, 1'b0);
      chk("t5_grant1", grant, 4'b0010);
      cycle(4'b1010, 1'b0, 1'b0);
      cycle(4'b1000, 1'b0, 1'b0);
      chk("t5_handoff", grant, 4'b1000);
      cycle(4'b1000, 1'b0, 1'b0);
      chk("t5_owners", {wr_owner_q.size() == 2, wr_owner_q[0] == 1, wr_owner_q[1] == 3}, 3'b111);

      // asynchronous reset during the 3rd word
      do_reset();
      run_writes(4'b0001, 1'b0, 1'b0, 2, 20, ncyc);
      req_valid = 4'b0001;
      #2;
      chk("t6_wr_before_rst", wr_en, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_grant", grant, 0);
      chk("t6_wr_en", wr_en, 0);
      chk("t6_wr_count", wr_count, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready", req_ready, 0);
      model_reset();
      @(posedge clk_wr);
      #1;
      rst = 1'b0;
      cycle(4'b0011, 1'b0, 1'b0);
      chk("t6_first_after_rst", grant, 4'b0001);

      // randomized traffic
      rv = '0;
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (rv[i]) rv[i] = ($urandom_range(0, 9) != 0);
            else       rv[i] = ($urandom_range(0, 1) != 0);
         end
         cycle(rv, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      end
      chk("sb_left", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
